xunit_sha2_round: RTL and testbench

XUNIT_SHA2_ROUND -- requirements
Module: xunit_sha2_round

---
 rtl/xunit_sha2_round.sv | 151 +++++++++++++++
 tb/tb_xunit_sha2_round.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xunit_sha2_round.sv
// SHA-2 compression round engine: start delay, one round per enabled clock, then an optional
// feed-forward of the latched IV. DATA_W=32 gives SHA-256 functions; DATA_W=64 gives SHA-512.
module xunit_sha2_round #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned ROUNDS  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [DATA_W-1:0]  in5,
  input  logic [DATA_W-1:0]  in6,
  input  logic [DATA_W-1:0]  in7,
  input  logic [DATA_W-1:0]  in8,
  input  logic [DATA_W-1:0]  in9,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               ff0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned S0_A  = (DATA_W == 64) ? 28 : 2;
  localparam int unsigned S0_B  = (DATA_W == 64) ? 34 : 13;
  localparam int unsigned S0_C  = (DATA_W == 64) ? 39 : 22;
  localparam int unsigned S1_A  = (DATA_W == 64) ? 14 : 6;
  localparam int unsigned S1_B  = (DATA_W == 64) ? 18 : 11;
  localparam int unsigned S1_C  = (DATA_W == 64) ? 41 : 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ROUND,
    ST_FEED,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DELAY_W-1:0]      dly_q, dly_d;
  logic [CNT_W-1:0]        rnd_q, rnd_d;
  logic [7:0][DATA_W-1:0]  st_q, st_d;
  logic [7:0][DATA_W-1:0]  iv_q, iv_d;
  logic                    done_q, done_d;

  logic [7:0][DATA_W-1:0]  in_c, rin_c, rnd_c;
  logic [DATA_W-1:0]       s0_c, s1_c, ch_c, maj_c, t1_c, t2_c;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  assign in_c = {in7, in6, in5, in4, in3, in2, in1, in0};

  // Round 0 works on the input words; every later round on the registered state.
  assign rin_c = (state_q == ST_DELAY) ? in_c : st_q;

  // One SHA-2 round on rin_c with W=in8, K=in9.
  always_comb begin
    s1_c  = rotr(rin_c[4], S1_A) ^ rotr(rin_c[4], S1_B) ^ rotr(rin_c[4], S1_C);
    ch_c  = (rin_c[4] & rin_c[5]) ^ (~rin_c[4] & rin_c[6]);
    t1_c  = rin_c[7] + s1_c + ch_c + in9 + in8;
    s0_c  = rotr(rin_c[0], S0_A) ^ rotr(rin_c[0], S0_B) ^ rotr(rin_c[0], S0_C);
    maj_c = (rin_c[0] & rin_c[1]) ^ (rin_c[0] & rin_c[2]) ^ (rin_c[1] & rin_c[2]);
    t2_c  = s0_c + maj_c;
    rnd_c    = rin_c << DATA_W;
    rnd_c[0] = t1_c + t2_c;
    rnd_c[4] = rin_c[3] + t1_c;
  end

  // Next-state logic; a run pulse overrides everything, otherwise running gates all progress.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    iv_d    = iv_q;
    done_d  = 1'b0;
    if (run) begin
      state_d = ST_DELAY;
      dly_d   = delay0;
      rnd_d   = '0;
    end else if (running) begin
      case (state_q)
        ST_DELAY: begin
          if (dly_q != '0) begin
            dly_d = dly_q - DELAY_W'(1);
          end else begin
            st_d  = rnd_c;
            iv_d  = in_c;
            rnd_d = CNT_W'(1);
            if (ROUNDS == 1) state_d = ff0 ? ST_FEED : ST_DONE;
            else             state_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          st_d = rnd_c;
          if (rnd_q == CNT_W'(ROUNDS - 1)) state_d = ff0 ? ST_FEED : ST_DONE;
          else                             rnd_d   = rnd_q + CNT_W'(1);
        end
        ST_FEED: begin
          for (int i = 0; i < 8; i++) st_d[i] = st_q[i] + iv_q[i];
          state_d = ST_DONE;
        end
        default: ;
      endcase
    end
    done_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      rnd_q   <= '0;
      st_q    <= '0;
      iv_q    <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      iv_q    <= iv_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign out0 = st_q[0];
  assign out1 = st_q[1];
  assign out2 = st_q[2];
  assign out3 = st_q[3];
  assign out4 = st_q[4];
  assign out5 = st_q[5];
  assign out6 = st_q[6];
  assign out7 = st_q[7];

endmodule

// File: tb/tb_xunit_sha2_round.sv
// Bench for xunit_sha2_round: SHA-256 and SHA-512 "abc" blocks checked every cycle against an
// in-bench SHA-2 model, with delay, stall, restart and mid-run reset scenarios.
module tb_xunit_sha2_round;
  typedef logic [63:0] w64_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        running = 1'b0;
  logic        run     = 1'b0;
  logic        ff0     = 1'b0;
  logic [31:0] delay0  = '0;
  w64_t        din   [10];
  logic [31:0] a_out [8];
  w64_t        b_out [8];
  logic        a_done, b_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xunit_sha2_round #(.DATA_W(32), .DELAY_W(32), .ROUNDS(64)) u_a (
    .clk(clk), .rst_n(rst_n), .running(running), .run(run), .done(a_done),
    .in0(din[0][31:0]), .in1(din[1][31:0]), .in2(din[2][31:0]), .in3(din[3][31:0]),
    .in4(din[4][31:0]), .in5(din[5][31:0]), .in6(din[6][31:0]), .in7(din[7][31:0]),
    .in8(din[8][31:0]), .in9(din[9][31:0]), .delay0(delay0), .ff0(ff0),
    .out0(a_out[0]), .out1(a_out[1]), .out2(a_out[2]), .out3(a_out[3]),
    .out4(a_out[4]), .out5(a_out[5]), .out6(a_out[6]), .out7(a_out[7]));

  xunit_sha2_round #(.DATA_W(64), .DELAY_W(32), .ROUNDS(80)) u_b (
    .clk(clk), .rst_n(rst_n), .running(running), .run(run), .done(b_done),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .in8(din[8]), .in9(din[9]), .delay0(delay0), .ff0(ff0),
    .out0(b_out[0]), .out1(b_out[1]), .out2(b_out[2]), .out3(b_out[3]),
    .out4(b_out[4]), .out5(b_out[5]), .out6(b_out[6]), .out7(b_out[7]));

  // SHA-512 constants; SHA-256 uses the upper 32 bits of the first 64 (and of the IV).
  w64_t K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
  w64_t IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  int   cur_w = 32;
  int   cur_r = 64;
  w64_t m_k [80];
  w64_t m_w [80];
  w64_t m_iv [8];
  w64_t m_tr [80][8];
  w64_t m_fin [8];

  w64_t exp_out [8];
  logic exp_done = 1'b1;

  function automatic w64_t msk(input w64_t x);
    return (cur_w == 64) ? x : (x & 64'h0000_0000_ffff_ffff);
  endfunction

  function automatic w64_t rr(input w64_t x, input int n);
    return msk((x >> n) | (x << (cur_w - n)));
  endfunction

  function automatic w64_t sg0(input w64_t x);
    return (cur_w == 64) ? (rr(x, 1) ^ rr(x, 8) ^ (x >> 7)) : (rr(x, 7) ^ rr(x, 18) ^ (x >> 3));
  endfunction

  function automatic w64_t sg1(input w64_t x);
    return (cur_w == 64) ? (rr(x, 19) ^ rr(x, 61) ^ (x >> 6)) : (rr(x, 17) ^ rr(x, 19) ^ (x >> 10));
  endfunction

  function automatic w64_t bs0(input w64_t x);
    return (cur_w == 64) ? (rr(x, 28) ^ rr(x, 34) ^ rr(x, 39)) : (rr(x, 2) ^ rr(x, 13) ^ rr(x, 22));
  endfunction

  function automatic w64_t bs1(input w64_t x);
    return (cur_w == 64) ? (rr(x, 14) ^ rr(x, 18) ^ rr(x, 41)) : (rr(x, 6) ^ rr(x, 11) ^ rr(x, 25));
  endfunction

  // Reference SHA-2 of the padded "abc" block: per-round state trace and feed-forward digest.
  function automatic void build_model(input int w);
    w64_t s [8];
    w64_t t1, t2;
    cur_w = w;
    cur_r = (w == 64) ? 80 : 64;
    for (int i = 0; i < 8; i++)  m_iv[i] = (w == 64) ? IV512[i] : (IV512[i] >> 32);
    for (int i = 0; i < 80; i++) m_k[i]  = (w == 64) ? K512[i]  : (K512[i] >> 32);
    for (int i = 0; i < 16; i++) m_w[i]  = '0;
    m_w[0]  = (w == 64) ? 64'h6162638000000000 : 64'h0000000061626380;
    m_w[15] = 64'h18;
    for (int t = 16; t < 80; t++) m_w[t] = msk(sg1(m_w[t-2]) + m_w[t-7] + sg0(m_w[t-15]) + m_w[t-16]);
    for (int i = 0; i < 8; i++) s[i] = m_iv[i];
    for (int t = 0; t < cur_r; t++) begin
      t1 = msk(s[7] + bs1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + m_k[t] + m_w[t]);
      t2 = msk(bs0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2])));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = msk(s[4] + t1);
      s[0] = msk(t1 + t2);
      for (int i = 0; i < 8; i++) m_tr[t][i] = s[i];
    end
    for (int i = 0; i < 8; i++) m_fin[i] = msk(s[i] + m_iv[i]);
  endfunction

  function automatic w64_t act(input int i);
    return (cur_w == 64) ? b_out[i] : {32'h0, a_out[i]};
  endfunction

  function automatic logic act_done();
    return (cur_w == 64) ? b_done : a_done;
  endfunction

  task automatic chk(input string name, input w64_t got, input w64_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of the active instance against the expected state.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) chk($sformatf("out%0d", i), act(i), exp_out[i]);
    chk("done", 64'(act_done()), 64'(exp_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iv(input bit junk);
    for (int i = 0; i < 8; i++) din[i] = junk ? w64_t'({$urandom, $urandom}) : m_iv[i];
  endtask

  // One run: run pulse, dly idle edges, rounds with optional stall/restart/reset, optional feed.
  task automatic do_run(input int dly, input bit ff, input int stall_t, input int stall_n,
                        input int abort_t, input bit abort_rst);
    int t;
    bit aborted;
    delay0 = 32'(dly);
    running = 1'b1;
    ff0 = !ff;
    set_iv(1'b1);
    run = 1'b1;
    tick();
    run = 1'b0;
    exp_done = 1'b0;
    repeat (dly) tick();
    t = 0;
    aborted = 1'b0;
    while (t < cur_r) begin
      if (t == stall_t) begin
        running = 1'b0;
        din[8] = w64_t'({$urandom, $urandom});
        din[9] = w64_t'({$urandom, $urandom});
        repeat (stall_n) tick();
        running = 1'b1;
      end
      if (t == abort_t && !aborted) begin
        aborted = 1'b1;
        if (abort_rst) begin
          #1 rst_n = 1'b0;
          for (int i = 0; i < 8; i++) exp_out[i] = '0;
          exp_done = 1'b1;
          #1;
          chk("rst_done_now", 64'(act_done()), 64'h1);
          chk("rst_out0_now", act(0), 64'h0);
          repeat (3) tick();
          rst_n = 1'b1;
          repeat (4) tick();
          return;
        end
        set_iv(1'b1);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (dly) tick();
        t = 0;
        continue;
      end
      if (t == 0) set_iv(1'b0);
      din[8] = m_w[t];
      din[9] = m_k[t];
      ff0 = (t == cur_r - 1) ? ff : !ff;
      tick();
      for (int i = 0; i < 8; i++) exp_out[i] = m_tr[t][i];
      if (t == 0) begin
        set_iv(1'b1);
        if (cur_w == 32) begin
          chk("round0_a", act(0), 64'h5d6aebcd);
          chk("round0_e", act(4), 64'hfa2a4622);
        end
      end
      if (t == cur_r - 1 && !ff) exp_done = 1'b1;
      t++;
    end
    ff0 = !ff;
    if (ff) begin
      tick();
      for (int i = 0; i < 8; i++) exp_out[i] = m_fin[i];
      exp_done = 1'b1;
    end
    repeat (3) tick();
    if (ff && cur_w == 32) begin
      chk("sha256_h0", act(0), 64'hba7816bf);
      chk("sha256_h7", act(7), 64'hf20015ad);
    end
    if (ff && cur_w == 64) begin
      chk("sha512_h0", act(0), 64'hddaf35a193617aba);
      chk("sha512_h7", act(7), 64'h2a9ac94fa54ca49f);
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) din[i] = '0;
    for (int i = 0; i < 8; i++) exp_out[i] = '0;
    build_model(32);
    chk("model256_h0", m_fin[0], 64'hba7816bf);
    tick();
    chk("reset_done", 64'(a_done), 64'h1);
    chk("reset_out7", {32'h0, a_out[7]}, 64'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_run(0, 1'b1, -1, 0, -1, 1'b0);
    do_run(3, 1'b0, -1, 0, -1, 1'b0);
    do_run(0, 1'b1, 30, 5, -1, 1'b0);
    do_run(2, 1'b1, -1, 0, 20, 1'b0);
    do_run(1, 1'b1, -1, 0, 30, 1'b1);

    build_model(64);
    chk("model512_h0", m_fin[0], 64'hddaf35a193617aba);
    do_run(1, 1'b1, 40, 3, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
